// File: rtl/core_pipe_pkg.sv
// Shared types for the core pipeline: per-boundary stage bundles, their
// write-enable kill masks, and the occupancy state of an elastic stage.
package core_pipe_pkg;

    // IF/ID boundary bundle
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_bundle_t;

    // ID/EX boundary bundle
    typedef struct packed {
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] immediate;
        logic [3:0]  alu_op;
        logic        regfile_we;
        logic [1:0]  rd_data_sel;
        logic        lsu_we;
        logic        lsu_sign_extend;
        logic [1:0]  data_width;
    } id_ex_bundle_t;

    // EX/MEMPREP boundary bundle
    typedef struct packed {
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic [31:0] alu_result;
        logic        regfile_we;
        logic [1:0]  rd_data_sel;
        logic        lsu_we;
        logic        lsu_sign_extend;
        logic [1:0]  data_width;
        logic [31:0] rs2_data;
        logic [31:0] immediate;
    } ex_mem_bundle_t;

    // MEMPREP/WB boundary bundle
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] rd_data;
        logic        regfile_we;
    } mem_wb_bundle_t;

    localparam int IF_ID_W  = $bits(if_id_bundle_t);
    localparam int ID_EX_W  = $bits(id_ex_bundle_t);
    localparam int EX_MEM_W = $bits(ex_mem_bundle_t);
    localparam int MEM_WB_W = $bits(mem_wb_bundle_t);

    // A fetched bubble carries no side effects, so nothing needs killing.
    localparam if_id_bundle_t IF_ID_KILL_MASK = '0;

    // Only the architectural write enables are cleared on an invalid entry.
    localparam id_ex_bundle_t ID_EX_KILL_MASK = '{
        pc4:             32'd0,
        rd:              5'd0,
        rs1_data:        32'd0,
        rs2_data:        32'd0,
        immediate:       32'd0,
        alu_op:          4'd0,
        regfile_we:      1'b1,
        rd_data_sel:     2'd0,
        lsu_we:          1'b1,
        lsu_sign_extend: 1'b0,
        data_width:      2'd0
    };

    localparam ex_mem_bundle_t EX_MEM_KILL_MASK = '{
        pc4:             32'd0,
        rd:              5'd0,
        alu_result:      32'd0,
        regfile_we:      1'b1,
        rd_data_sel:     2'd0,
        lsu_we:          1'b1,
        lsu_sign_extend: 1'b0,
        data_width:      2'd0,
        rs2_data:        32'd0,
        immediate:       32'd0
    };

    localparam mem_wb_bundle_t MEM_WB_KILL_MASK = '{
        rd:         5'd0,
        rd_data:    32'd0,
        regfile_we: 1'b1
    };

    // Encoded as {main_valid, skid_valid} so each bit is directly usable.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'b00,
        OCC_ONE   = 2'b10,
        OCC_FULL  = 2'b11
    } occ_state_t;

    // Number of held entries for a given occupancy state.
    function automatic logic [1:0] occ_count(input occ_state_t s);
        case (s)
            OCC_ONE:  return 2'd1;
            OCC_FULL: return 2'd2;
            default:  return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipeline_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake, flush,
// and write-enable kill of invalid entries. SKID=1 adds a second entry so
// in_ready comes from a flop instead of from the downstream out_ready.
module pipeline_stage_reg
    import core_pipe_pkg::*;
#(
    parameter int               WIDTH      = 64,
    parameter bit               SKID       = 1'b1,
    parameter logic [WIDTH-1:0] KILL_MASK  = '0,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_invalid,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_invalid,
    input  logic             flush,
    output logic [1:0]       occupancy
);

    // Clears the masked write-enable bits of an entry captured as invalid.
    function automatic logic [WIDTH-1:0] apply_kill(input logic [WIDTH-1:0] data,
                                                    input logic             invalid);
        return invalid ? (data & ~KILL_MASK) : data;
    endfunction

    logic             main_valid;
    logic [WIDTH-1:0] main_data;
    logic             main_invalid;
    logic             in_xfer;
    logic             out_xfer;
    logic [WIDTH-1:0] cap_data;

    assign in_xfer     = in_valid & in_ready;
    assign out_xfer    = main_valid & out_ready;
    assign cap_data    = apply_kill(in_data, in_invalid);
    assign out_valid   = main_valid;
    assign out_data    = main_data;
    assign out_invalid = main_invalid;

    if (SKID) begin : g_skid
        occ_state_t       state_q;
        occ_state_t       state_d;
        logic             skid_valid;
        logic [WIDTH-1:0] skid_data;
        logic             skid_invalid;
        logic             load_main_in;
        logic             load_main_skid;
        logic             load_skid;

        assign main_valid = state_q[1];
        assign skid_valid = state_q[0];
        assign in_ready   = ~skid_valid;
        assign occupancy  = occ_count(state_q);

        // Occupancy state register
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= OCC_EMPTY;
            end else begin
                state_q <= state_d;
            end
        end

        // Next occupancy and which entry gets loaded from where
        always_comb begin
            state_d        = state_q;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
            if (flush) begin
                state_d = OCC_EMPTY;
            end else begin
                case (state_q)
                    OCC_EMPTY: begin
                        if (in_xfer) begin
                            state_d      = OCC_ONE;
                            load_main_in = 1'b1;
                        end
                    end
                    OCC_ONE: begin
                        if (in_xfer && out_xfer) begin
                            load_main_in = 1'b1;
                        end else if (in_xfer) begin
                            state_d   = OCC_FULL;
                            load_skid = 1'b1;
                        end else if (out_xfer) begin
                            state_d = OCC_EMPTY;
                        end
                    end
                    OCC_FULL: begin
                        // in_ready is low here, so only the drain can happen.
                        if (out_xfer) begin
                            state_d        = OCC_ONE;
                            load_main_skid = 1'b1;
                        end
                    end
                    default: begin
                        state_d = OCC_EMPTY;
                    end
                endcase
            end
        end

        // Head entry: from upstream, from the skid entry, or marked empty
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                main_data    <= RESET_DATA;
                main_invalid <= 1'b1;
            end else if (state_d == OCC_EMPTY) begin
                main_invalid <= 1'b1;
            end else if (load_main_skid) begin
                main_data    <= skid_data;
                main_invalid <= skid_invalid;
            end else if (load_main_in) begin
                main_data    <= cap_data;
                main_invalid <= in_invalid;
            end
        end

        // Skid entry payload; only meaningful while skid_valid is set
        always_ff @(posedge clk) begin
            if (load_skid) begin
                skid_data    <= cap_data;
                skid_invalid <= in_invalid;
            end
        end
    end else begin : g_single
        assign in_ready  = ~main_valid | out_ready;
        assign occupancy = {1'b0, main_valid};

        // Single entry valid: a simultaneous in/out transfer keeps it set
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                main_valid <= 1'b0;
            end else if (flush) begin
                main_valid <= 1'b0;
            end else if (in_xfer) begin
                main_valid <= 1'b1;
            end else if (out_xfer) begin
                main_valid <= 1'b0;
            end
        end

        // Single entry payload, replaced in place on every in-transfer
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                main_data    <= RESET_DATA;
                main_invalid <= 1'b1;
            end else if (flush) begin
                main_invalid <= 1'b1;
            end else if (in_xfer) begin
                main_data    <= cap_data;
                main_invalid <= in_invalid;
            end else if (out_xfer) begin
                main_invalid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Bench for pipeline_stage_reg: a SKID=1 and a SKID=0 instance driven by the
// same stimulus, each compared against an entry-queue reference model.
module tb_pipeline_stage_reg;

    localparam int          W      = 16;
    localparam logic [15:0] MASK_A = 16'h0001;
    localparam logic [15:0] MASK_B = 16'h00F0;
    localparam logic [15:0] RST_A  = 16'h5A5A;
    localparam logic [15:0] RST_B  = 16'hC3C3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_invalid;
    logic          out_ready;
    logic          flush;

    logic          a_in_ready, a_out_valid, a_out_invalid;
    logic [W-1:0]  a_out_data;
    logic [1:0]    a_occ;
    logic          b_in_ready, b_out_valid, b_out_invalid;
    logic [W-1:0]  b_out_data;
    logic [1:0]    b_occ;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: each queue entry is {invalid, payload}, head first.
    logic [W:0] qa[$];
    logic [W:0] qb[$];

    always #5 clk = ~clk;

    pipeline_stage_reg #(.WIDTH(W), .SKID(1'b1), .KILL_MASK(MASK_A), .RESET_DATA(RST_A)) u_skid (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data), .in_invalid(in_invalid),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .out_invalid(a_out_invalid), .flush(flush), .occupancy(a_occ)
    );

    pipeline_stage_reg #(.WIDTH(W), .SKID(1'b0), .KILL_MASK(MASK_B), .RESET_DATA(RST_B)) u_single (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data), .in_invalid(in_invalid),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .out_invalid(b_out_invalid), .flush(flush), .occupancy(b_occ)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [W:0] entry(input logic [W-1:0] d, input logic inv,
                                         input logic [W-1:0] mask);
        return {inv, inv ? (d & ~mask) : d};
    endfunction

    // Advance both models by one clock edge using the current inputs.
    task automatic model_step();
        logic ra, rb;
        ra = (qa.size() < 2);
        rb = (qb.size() == 0) || out_ready;
        if (flush) begin
            qa.delete();
            qb.delete();
        end else begin
            if (qa.size() > 0 && out_ready) void'(qa.pop_front());
            if (in_valid && ra) qa.push_back(entry(in_data, in_invalid, MASK_A));
            if (qb.size() > 0 && out_ready) void'(qb.pop_front());
            if (in_valid && rb) qb.push_back(entry(in_data, in_invalid, MASK_B));
        end
    endtask

    task automatic check_model();
        chk("a_out_valid", a_out_valid, qa.size() > 0);
        chk("a_occupancy", a_occ, qa.size());
        chk("a_in_ready", a_in_ready, qa.size() < 2);
        if (qa.size() > 0) begin
            chk("a_out_data", a_out_data, qa[0][W-1:0]);
            chk("a_out_invalid", a_out_invalid, qa[0][W]);
        end
        chk("b_out_valid", b_out_valid, qb.size() > 0);
        chk("b_occupancy", b_occ, qb.size());
        chk("b_in_ready", b_in_ready, (qb.size() == 0) || out_ready);
        if (qb.size() > 0) begin
            chk("b_out_data", b_out_data, qb[0][W-1:0]);
            chk("b_out_invalid", b_out_invalid, qb[0][W]);
        end
    endtask

    task automatic drive(input logic iv, input logic [W-1:0] d, input logic ii,
                         input logic ordy, input logic fl);
        @(negedge clk);
        in_valid   = iv;
        in_data    = d;
        in_invalid = ii;
        out_ready  = ordy;
        flush      = fl;
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic cycle(input logic iv, input logic [W-1:0] d, input logic ii,
                         input logic ordy, input logic fl);
        drive(iv, d, ii, ordy, fl);
        finish_cycle();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_invalid = 1'b0;
        out_ready = 1'b0; flush = 1'b0;
        #1;
        chk("rst_a_out_valid", a_out_valid, 1'b0);
        chk("rst_a_out_invalid", a_out_invalid, 1'b1);
        chk("rst_a_out_data", a_out_data, RST_A);
        chk("rst_a_occupancy", a_occ, 2'd0);
        chk("rst_a_in_ready", a_in_ready, 1'b1);
        chk("rst_b_out_data", b_out_data, RST_B);
        chk("rst_b_out_invalid", b_out_invalid, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Streaming 1..8: one output per cycle, occupancy stays at one
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, W'(i), 1'b0, 1'b1, 1'b0);
            chk("stream_data", a_out_data, i);
            chk("stream_occ", a_occ, 2'd1);
        end
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Back-pressure: 0xA, 0xB fill both entries, 0xC waits upstream
        cycle(1'b1, 16'h000A, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h000B, 1'b0, 1'b0, 1'b0);
        chk("bp_full_occ", a_occ, 2'd2);
        chk("bp_full_ready", a_in_ready, 1'b0);
        cycle(1'b1, 16'h000C, 1'b0, 1'b0, 1'b0);
        chk("bp_hold_data", a_out_data, 16'h000A);
        cycle(1'b1, 16'h000C, 1'b0, 1'b1, 1'b0);
        chk("bp_drain_b", a_out_data, 16'h000B);
        cycle(1'b1, 16'h000C, 1'b0, 1'b1, 1'b0);
        chk("bp_drain_c", a_out_data, 16'h000C);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("bp_empty", a_out_valid, 1'b0);

        // Kill: invalid entry has its masked bits cleared at capture
        cycle(1'b1, 16'h00FF, 1'b1, 1'b1, 1'b0);
        chk("kill_data", a_out_data, 16'h00FE);
        chk("kill_invalid", a_out_invalid, 1'b1);
        chk("kill_data_b", b_out_data, 16'h000F);
        cycle(1'b1, 16'h00FF, 1'b0, 1'b1, 1'b0);
        chk("nokill_data", a_out_data, 16'h00FF);
        chk("nokill_invalid", a_out_invalid, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Flush while full, with a concurrent in-transfer of 0x55
        cycle(1'b1, 16'h0011, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h0022, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h0055, 1'b0, 1'b0, 1'b1);
        chk("flush_valid", a_out_valid, 1'b0);
        chk("flush_occ", a_occ, 2'd0);
        chk("flush_invalid", a_out_invalid, 1'b1);
        chk("flush_b_valid", b_out_valid, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("flush_no55", a_out_valid, 1'b0);

        // SKID=0 replace: head consumed and reloaded on the same edge
        cycle(1'b1, 16'h0033, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 16'h0077, 1'b0, 1'b1, 1'b0);
        #1;
        chk("replace_comb_ready", b_in_ready, 1'b1);
        finish_cycle();
        chk("replace_data", b_out_data, 16'h0077);
        chk("replace_valid", b_out_valid, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 9) < 7, W'($urandom), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
        end

        // Asynchronous reset between edges while the skid stage is full
        cycle(1'b1, 16'h0101, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h0202, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h0303, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_occ", a_occ, 2'd2);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_a_valid", a_out_valid, 1'b0);
        chk("arst_a_occ", a_occ, 2'd0);
        chk("arst_a_ready", a_in_ready, 1'b1);
        chk("arst_a_data", a_out_data, RST_A);
        chk("arst_b_valid", b_out_valid, 1'b0);
        chk("arst_b_ready", b_in_ready, 1'b1);
        qa.delete();
        qb.delete();
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        rst = 1'b0;
        cycle(1'b1, 16'h0404, 1'b0, 1'b1, 1'b0);
        chk("post_rst_data", a_out_data, 16'h0404);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_stage_reg.md
Name: pipeline_stage_reg

Overview:
- Generic parametrised inter-stage pipeline register, the successor to the fixed per-stage EX/MEMPREP-style registers.
- Carries a packed payload of WIDTH bits with valid/ready handshake, stall back-pressure, synchronous flush and invalid-instruction write-enable kill.
- Optional skid entry (SKID=1) registers the upstream ready, breaking the combinational ready path between stages.
- One instance sits between each pair of core stages (IF/ID, ID/EX, EX/MEMPREP, MEMPREP/WB).

Parameters:
WIDTH, 64, payload width in bits (packed stage bundle).
SKID, 1, 1 = two-entry elastic stage with registered in_ready; 0 = single entry with combinational in_ready.
KILL_MASK, '0 (WIDTH bits), payload bits forced to 0 when an entry is captured with in_invalid=1 (write-enable bits such as regfile_we, lsu_we).
RESET_DATA, '0 (WIDTH bits), value of out_data after reset.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  upstream offers an entry
in_ready  output  1  stage can accept an entry this cycle
in_data  input  WIDTH  upstream payload
in_invalid  input  1  upstream entry is a bubble or invalidated instruction
out_valid  output  1  stage holds an entry for downstream
out_ready  input  1  downstream consumes the entry this cycle
out_data  output  WIDTH  head entry payload
out_invalid  output  1  head entry is invalid
flush  input  1  synchronous squash of all held entries
occupancy  output  2  number of held entries (0..2; max 1 when SKID=0)

Behaviour:
- Reset (async, any time, including mid-transfer): out_valid=0, out_invalid=1, out_data=RESET_DATA, skid empty, occupancy=0. in_ready=1 while rst is high and after release.
- Transfer in: in_valid & in_ready at a rising edge. Transfer out: out_valid & out_ready at a rising edge.
- Kill: the captured payload is (in_data & ~KILL_MASK) when in_invalid=1, otherwise in_data. The captured out_invalid equals in_invalid. The mask is applied at capture, never at the output.
- Latency: an entry taken into an empty stage appears on out_* the next cycle (1 cycle). Entries leave in order.
- SKID=0:
  - in_ready = !out_valid | out_ready (combinational).
  - A simultaneous in and out transfer replaces the head in the same edge.
  - With out_valid=1 and out_ready=0, the head holds its value.
- SKID=1: in_ready = !skid_valid, driven directly from a flop. State {main_valid, skid_valid}, encoded as EMPTY, ONE, FULL:
  - EMPTY: on in-transfer go to ONE (main loaded).
  - ONE, in only (out_ready=0): go to FULL (skid loaded).
  - ONE, out only: go to EMPTY.
  - ONE, in and out together: stay in ONE (main replaced).
  - FULL, out-transfer: skid moves to main, go to ONE. in_ready=0, so no input is taken.
  - FULL, no out-transfer: hold both entries.
- out_valid = main_valid. occupancy is the entry count in both configurations.
- flush:
  - Highest priority: at the next edge all entries are emptied (out_valid=0, occupancy=0, out_invalid=1).
  - Any in-transfer in the flush cycle is consumed and discarded.
  - out_data keeps its last value, which is a don't-care.
- Stall hold: while out_ready=0, out_data, out_invalid and out_valid are stable, i.e. not changed by in_* activity.
- out_valid never drops without an out-transfer, flush or rst.

Decomposition:
- Shared package core_pipe_pkg holds:
  - Packed struct typedefs per stage boundary (ex_mem_bundle_t: pc4, rd, alu_result, regfile_we, rd_data_sel, lsu_we, lsu_sign_extend, data_width, rs2_data, immediate).
  - Matching KILL_MASK localparams and the occupancy state enum.
- No sub-module. The skid entry is generate-guarded inside the block.

Test Plan:
- Reset mid-stream: hold FULL (two entries), assert rst asynchronously between edges -> out_valid=0, occupancy=0, in_ready=1 immediately, without waiting for an edge.
- Streaming, SKID=1: payloads 1..8 with in_valid=1, out_ready=1 -> out_data 1..8 in order, one per cycle from cycle 1, no gaps, occupancy=1 throughout.
- Back-pressure: out_ready=0 for 3 cycles while sending 0xA, 0xB, 0xC -> FULL after 0xB, in_ready=0, 0xC held upstream. After release, output order is 0xA, 0xB, 0xC with none lost or duplicated.
- Kill: KILL_MASK=0x1, in_data=0xFF, in_invalid=1 -> out_data=0xFE, out_invalid=1. Next entry 0xFF with in_invalid=0 -> out_data=0xFF.
- Flush: FULL state, flush=1 together with in_valid=1 (0x55) -> next cycle out_valid=0, occupancy=0, and 0x55 never appears on the output.
- SKID=0 replace: out_valid=1, out_ready=1, in_valid=1 with 0x77 -> next cycle out_data=0x77, out_valid=1, in_ready was 1 combinationally.
